// File: rtl/fft_stage_ctrl_if.sv
// fft_stage_ctrl_if
//   Control bundle between the FFT stage controller and its user.
//   Handshake: the user raises start; the block is accepted on the rising
//   edge where start=1, ready=1 and abort=0. ready is decoded from state
//   only, so start never feeds back into ready within a cycle.
//   Ports (slave = controller side):
//     start, abort             : requests into the controller
//     ready                    : controller idle, start will be accepted
//     cnt                      : in-block cycle index
//     shift_en/sel_diff        : shift-register valid / diff-path select
//     bfly_valid/twd_valid     : butterfly enable / twiddle output valid
//     done, blk_cnt, err       : end-of-block pulse, block count, sticky error
interface fft_stage_ctrl_if #(
    parameter int CNT_W = 5
);
    logic             start;
    logic             abort;
    logic             ready;
    logic [CNT_W-1:0] cnt;
    logic             shift_en;
    logic             sel_diff;
    logic             bfly_valid;
    logic             twd_valid;
    logic             done;
    logic [7:0]       blk_cnt;
    logic             err;

    modport slave (
        input  start, abort,
        output ready, cnt, shift_en, sel_diff, bfly_valid, twd_valid,
               done, blk_cnt, err
    );

    modport master (
        output start, abort,
        input  ready, cnt, shift_en, sel_diff, bfly_valid, twd_valid,
               done, blk_cnt, err
    );
endinterface

// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl
//   Sequences one radix-2 SDF FFT stage: a fill half-block, a butterfly
//   half-block, then a drain while the twiddle multiplier pipeline empties.
//   Ports:
//     clk          : clock, rising edge
//     rstn         : synchronous reset, active HIGH despite the name
//     bus (slave)  : control bundle, see fft_stage_ctrl_if
//     dbg_state_o  : current FSM state (0 IDLE, 1 FILL, 2 BFLY, 3 DRAIN)
module fft_stage_ctrl #(
    parameter  int HALF_CYC = 16,
    parameter  int TWD_LAT  = 4,
    localparam int CNT_W    = $clog2(2 * HALF_CYC)
) (
    input  logic                 clk,
    input  logic                 rstn,
    fft_stage_ctrl_if.slave      bus,
    output logic [1:0]           dbg_state_o
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_BFLY  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(HALF_CYC - 1);
    localparam logic [CNT_W-1:0] BFLY_LAST  = CNT_W'(2 * HALF_CYC - 1);
    localparam logic [3:0]       DRAIN_LAST = 4'(TWD_LAT - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           dcnt_q, dcnt_d;     // drain cycle index
    logic [TWD_LAT-1:0]   pipe_q, pipe_d;     // twiddle-valid delay line
    logic [7:0]           blk_q, blk_d;
    logic                 err_q, err_d;

    logic                 bfly_w;
    logic                 done_w;

    assign bfly_w = (state_q == S_BFLY);
    // The last drain cycle is also the last cycle the delay line holds a 1.
    assign done_w = (state_q == S_DRAIN) && (dcnt_q == DRAIN_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        pipe_d  = (pipe_q << 1) | TWD_LAT'(bfly_w);
        blk_d   = blk_q;
        err_d   = err_q;

        if (bus.start && (state_q != S_IDLE)) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                dcnt_d = '0;
                if (bus.start) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == FILL_LAST) begin
                    state_d = S_BFLY;
                end
            end
            S_BFLY: begin
                if (cnt_q == BFLY_LAST) begin
                    cnt_d   = '0;
                    dcnt_d  = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                dcnt_d = dcnt_q + 4'd1;
                if (dcnt_q == DRAIN_LAST) begin
                    dcnt_d  = '0;
                    state_d = S_IDLE;
                    blk_d   = blk_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over every transition, including a completing block.
        if (bus.abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            dcnt_d  = '0;
            pipe_d  = '0;
            blk_d   = blk_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            pipe_q  <= '0;
            blk_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            pipe_q  <= pipe_d;
            blk_q   <= blk_d;
            err_q   <= err_d;
        end
    end

    assign bus.ready      = (state_q == S_IDLE);
    assign bus.cnt        = cnt_q;
    assign bus.shift_en   = (state_q == S_FILL) || (state_q == S_BFLY);
    assign bus.sel_diff   = bfly_w;
    assign bus.bfly_valid = bfly_w;
    assign bus.twd_valid  = pipe_q[TWD_LAT-1];
    assign bus.done       = done_w;
    assign bus.blk_cnt    = blk_q;
    assign bus.err        = err_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_fft_stage_ctrl.sv
module tb_fft_stage_ctrl;
    localparam int H0 = 16;
    localparam int L0 = 4;
    localparam int H1 = 8;
    localparam int L1 = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_stage_ctrl_if #(.CNT_W(5)) bus0();
    fft_stage_ctrl_if #(.CNT_W(4)) bus1();
    logic [1:0] dbg0, dbg1;

    assign bus0.start = start;
    assign bus0.abort = abort;
    assign bus1.start = start;
    assign bus1.abort = abort;

    fft_stage_ctrl #(.HALF_CYC(H0), .TWD_LAT(L0)) dut0 (
        .clk(clk), .rstn(rst), .bus(bus0), .dbg_state_o(dbg0)
    );
    fft_stage_ctrl #(.HALF_CYC(H1), .TWD_LAT(L1)) dut1 (
        .clk(clk), .rstn(rst), .bus(bus1), .dbg_state_o(dbg1)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s inst%0d cyc=%0d: got %0d expected %0d (state0=%0d state1=%0d)",
                         name, inst, cyc, act, exp, dbg0, dbg1);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A block is described only by whether it is running and how many cycles
    // have elapsed since its first fill cycle; every output is a window on it.
    int   m_act[2];
    int   m_off[2];
    int   m_blk[2];
    int   m_err[2];
    logic [7:0] exp_q[$];
    int   t_a, t_o, t_b, t_e, t_h, t_l;

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_off[i] = 0; m_blk[i] = 0; m_err[i] = 0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            t_h = (i == 0) ? H0 : H1;
            t_l = (i == 0) ? L0 : L1;
            t_a = m_act[i]; t_o = m_off[i]; t_b = m_blk[i]; t_e = m_err[i];
            if (rst) begin
                t_a = 0; t_o = 0; t_b = 0; t_e = 0;
            end else begin
                if (start && t_a != 0) t_e = 1;
                if (abort) begin
                    t_a = 0; t_o = 0;
                end else if (t_a != 0) begin
                    if (t_o == 2 * t_h + t_l - 1) begin
                        t_a = 0; t_o = 0;
                        t_b = (t_b + 1) % 256;
                        if (i == 0) exp_q.push_back(8'(t_b));
                    end else begin
                        t_o = t_o + 1;
                    end
                end else if (start) begin
                    t_a = 1; t_o = 0;
                end
            end
            m_act[i] <= t_a; m_off[i] <= t_o; m_blk[i] <= t_b; m_err[i] <= t_e;
        end
    end

    task automatic cmp_inst(input int i, input logic rdy, input logic [31:0] cnt,
                            input logic sh, input logic sel, input logic bf,
                            input logic tw, input logic dn,
                            input logic [31:0] blk, input logic er);
        int h, l, o;
        logic a;
        h = (i == 0) ? H0 : H1;
        l = (i == 0) ? L0 : L1;
        a = (m_act[i] != 0);
        o = m_off[i];
        check("ready",      i, 32'(rdy), 32'(!a));
        check("cnt",        i, cnt, (a && o < 2 * h) ? o : 0);
        check("shift_en",   i, 32'(sh),  32'(a && o < 2 * h));
        check("sel_diff",   i, 32'(sel), 32'(a && o >= h && o < 2 * h));
        check("bfly_valid", i, 32'(bf),  32'(a && o >= h && o < 2 * h));
        check("twd_valid",  i, 32'(tw),  32'(a && o >= h + l && o < 2 * h + l));
        check("done",       i, 32'(dn),  32'(a && o == 2 * h + l - 1));
        check("blk_cnt",    i, blk, m_blk[i]);
        check("err",        i, 32'(er), m_err[i]);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_inst(0, bus0.ready, 32'(bus0.cnt), bus0.shift_en, bus0.sel_diff,
                     bus0.bfly_valid, bus0.twd_valid, bus0.done,
                     32'(bus0.blk_cnt), bus0.err);
            cmp_inst(1, bus1.ready, 32'(bus1.cnt), bus1.shift_en, bus1.sel_diff,
                     bus1.bfly_valid, bus1.twd_valid, bus1.done,
                     32'(bus1.blk_cnt), bus1.err);
            if (exp_q.size() > 0)
                check("blk_cnt_after_done", 0, 32'(bus0.blk_cnt), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input logic st, input logic ab, input logic rs);
        start = st;
        abort = ab;
        rst   = rs;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
    endtask

    // Window recorders for instance 0 (offsets relative to the start cycle).
    int sh_f, sh_l, bf_f, bf_l, tw_f, tw_l, dn_c, dn_f, dn_l, rd_l, er_f, cnt21, blk_f1, d1_f;

    task automatic run_block(input int extra_start, input int abort_at,
                             input int rst_at, input int len);
        int t0, kk;
        t0 = cyc;
        sh_f = -1; sh_l = -1; bf_f = -1; bf_l = -1; tw_f = -1; tw_l = -1;
        dn_c = 0; dn_f = -1; dn_l = -1; rd_l = -1; er_f = -1; cnt21 = -1;
        blk_f1 = -1; d1_f = -1;
        for (int k = 0; k < len; k++) begin
            tick(k == 0 || k == extra_start, k == abort_at, k == rst_at);
            kk = cyc - t0;
            if (bus0.shift_en)   begin if (sh_f < 0) sh_f = kk; sh_l = kk; end
            if (bus0.bfly_valid) begin if (bf_f < 0) bf_f = kk; bf_l = kk; end
            if (bus0.twd_valid)  begin if (tw_f < 0) tw_f = kk; tw_l = kk; end
            if (bus0.done)       begin dn_c++; if (dn_f < 0) dn_f = kk; dn_l = kk; end
            if (!bus0.ready) rd_l = kk;
            if (bus0.err && er_f < 0) er_f = kk;
            if (kk == 21) cnt21 = 32'(bus0.cnt);
            if (bus0.blk_cnt == 8'd1 && blk_f1 < 0) blk_f1 = kk;
            if (bus1.done && d1_f < 0) d1_f = kk;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset();
        chk_en = 1'b1;
        check("reset_ready", 0, 32'(bus0.ready), 1);
        check("reset_blk",   0, 32'(bus0.blk_cnt), 0);
        check("reset_twd",   0, 32'(bus0.twd_valid), 0);

        // Nominal block.
        run_block(-1, -1, -1, 40);
        check("nom_shift_first", 0, sh_f, 1);
        check("nom_shift_last",  0, sh_l, 32);
        check("nom_bfly_first",  0, bf_f, 17);
        check("nom_bfly_last",   0, bf_l, 32);
        check("nom_twd_first",   0, tw_f, 21);
        check("nom_twd_last",    0, tw_l, 36);
        check("nom_done_count",  0, dn_c, 1);
        check("nom_done_at",     0, dn_f, 36);
        check("nom_blk_at",      0, blk_f1, 37);
        check("nom_ready_back",  0, rd_l, 36);
        check("nom_small_done",  1, d1_f, 18);

        // Start while busy: timing unchanged, err raised.
        do_reset();
        run_block(10, -1, -1, 40);
        check("busy_twd_first", 0, tw_f, 21);
        check("busy_done_at",   0, dn_f, 36);
        check("busy_done_count",0, dn_c, 1);
        check("busy_err_from",  0, er_f, 11);
        check("busy_blk",       0, 32'(bus0.blk_cnt), 1);

        // Abort mid-butterfly.
        do_reset();
        run_block(-1, 20, -1, 40);
        check("abort_bfly_last", 0, bf_l, 20);
        check("abort_no_twd",    0, tw_f, -1);
        check("abort_no_done",   0, dn_c, 0);
        check("abort_cnt21",     0, cnt21, 0);
        check("abort_ready",     0, rd_l, 20);
        check("abort_blk",       0, 32'(bus0.blk_cnt), 0);

        // Reset mid-drain.
        do_reset();
        run_block(-1, -1, 34, 40);
        check("rst_twd_last", 0, tw_l, 34);
        check("rst_no_done",  0, dn_c, 0);
        check("rst_blk",      0, 32'(bus0.blk_cnt), 0);
        check("rst_err",      0, 32'(bus0.err), 0);

        // Back-to-back blocks.
        do_reset();
        run_block(37, -1, -1, 80);
        check("b2b_done_count", 0, dn_c, 2);
        check("b2b_done_first", 0, dn_f, 36);
        check("b2b_done_last",  0, dn_l, 73);
        check("b2b_shift_last", 0, sh_l, 69);
        check("b2b_err",        0, 32'(bus0.err), 0);
        check("b2b_blk",        0, 32'(bus0.blk_cnt), 2);

        // 256 blocks wrap the block counter.
        do_reset();
        for (int b = 0; b < 256; b++) run_block(-1, -1, -1, 37);
        check("wrap_blk0", 0, 32'(bus0.blk_cnt), 0);
        check("wrap_blk1", 1, 32'(bus1.blk_cnt), 0);
        check("wrap_err0", 0, 32'(bus0.err), 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 199) == 0);
        end
        tick(1'b0, 1'b0, 1'b0);
        check("exp_q_drained", 0, exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
